// File: rtl/idma_wr_cmd_gen_if.sv
// -----------------------------------------------------------------------------
// idma_wr_cmd_gen_if
// Write-request bus between the iDMA write command generator and the
// address FIFO / write channel.
//
//   wr_req          master->slave  address-FIFO push strobe
//   wr_addr         master->slave  request byte address
//   wr_num          master->slave  request length in 256-bit words
//   wr_addr_ready   slave->master  address FIFO not full
//   write_all_done  slave->master  completion pulse from the write channel
//
// Modports: master = command generator, slave = FIFO / write-channel side.
// -----------------------------------------------------------------------------
interface idma_wr_cmd_gen_if #(
    parameter int unsigned AXI_ADDR_WID = 32
);
    logic                    wr_req;
    logic [AXI_ADDR_WID-1:0] wr_addr;
    logic [31:0]             wr_num;
    logic                    wr_addr_ready;
    logic                    write_all_done;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_num,
        input  wr_addr_ready,
        input  write_all_done
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_num,
        output wr_addr_ready,
        output write_all_done
    );
endinterface

// File: rtl/idma_wr_cmd_gen.sv
// -----------------------------------------------------------------------------
// idma_wr_cmd_gen
// Turns a 2-D write descriptor (base, words per row, row count, row stride)
// into a stream of address-FIFO requests, one per row, then waits for the
// write channel to report completion.
//
// Build option: define IDMA_WR_CMD_4K_SPLIT_EN to split every row at each
// 4 KB address boundary (one request per piece). Undefined: one request per
// row and no split logic.
//
// Ports:
//   cclk, rst_n     clock, asynchronous active-low reset
//   cmd_valid/ready descriptor handshake (ready only in IDLE)
//   cmd_base_addr   first-row byte address (bits [4:0] ignored)
//   cmd_row_words   256-bit words per row
//   cmd_row_num     number of rows
//   cmd_row_stride  byte distance between row starts (bits [4:0] ignored)
//   cmd_abort       synchronous abort, wins over every other event
//   wr_if           write-request bus (master modport)
//   busy            not IDLE
//   cmd_done        one-cycle descriptor-complete pulse
//   cmd_err         one-cycle pulse after accepting a zero-sized descriptor
//   req_cnt         requests pushed for the current descriptor
// -----------------------------------------------------------------------------
module idma_wr_cmd_gen #(
    parameter int unsigned AXI_ADDR_WID = 32,
    parameter int unsigned ROW_CNT_WID  = 16
) (
    input  logic                    cclk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AXI_ADDR_WID-1:0] cmd_base_addr,
    input  logic [ROW_CNT_WID-1:0]  cmd_row_words,
    input  logic [ROW_CNT_WID-1:0]  cmd_row_num,
    input  logic [AXI_ADDR_WID-1:0] cmd_row_stride,
    input  logic                    cmd_abort,
    idma_wr_cmd_gen_if.master       wr_if,
    output logic                    busy,
    output logic                    cmd_done,
    output logic                    cmd_err,
    output logic [ROW_CNT_WID-1:0]  req_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_e;

    localparam logic [AXI_ADDR_WID-1:0] WORD_MASK = AXI_ADDR_WID'(31);

    state_e                  state_q,     state_d;
    logic [AXI_ADDR_WID-1:0] row_start_q, row_start_d;
    logic [AXI_ADDR_WID-1:0] stride_q,    stride_d;
    logic [ROW_CNT_WID-1:0]  row_words_q, row_words_d;
    logic [ROW_CNT_WID-1:0]  row_num_q,   row_num_d;
    logic [ROW_CNT_WID-1:0]  row_idx_q,   row_idx_d;
    logic [ROW_CNT_WID-1:0]  req_cnt_q,   req_cnt_d;
    logic [AXI_ADDR_WID-1:0] wr_addr_q,   wr_addr_d;
    logic [31:0]             wr_num_q,    wr_num_d;
    logic                    cmd_done_q,  cmd_done_d;
    logic                    cmd_err_q,   cmd_err_d;

    logic                    push;
    logic                    last_row;
    logic [AXI_ADDR_WID-1:0] base_aligned;
    logic [AXI_ADDR_WID-1:0] next_row_addr;

`ifdef IDMA_WR_CMD_4K_SPLIT_EN
    logic [ROW_CNT_WID-1:0]  words_left_q, words_left_d;
    logic [ROW_CNT_WID-1:0]  words_after;
    logic [AXI_ADDR_WID-1:0] next_piece_addr;

    // Words that fit before the next 4 KB boundary, capped by what is left.
    function automatic logic [31:0] piece_len(input logic [11:0]            lo_addr,
                                              input logic [ROW_CNT_WID-1:0] words);
        logic [12:0] room;
        room = (13'd4096 - {1'b0, lo_addr}) >> 5;
        if (32'(words) < 32'(room)) return 32'(words);
        else                        return 32'(room);
    endfunction
`endif

    // Abort masks the push so a request is never handed over in the cycle
    // the descriptor is being dropped.
    assign push         = (state_q == ISSUE) && wr_if.wr_addr_ready && !cmd_abort;
    assign last_row     = (row_idx_q + ROW_CNT_WID'(1)) == row_num_q;
    assign base_aligned = cmd_base_addr & ~WORD_MASK;

    always_comb begin
        state_d       = state_q;
        row_start_d   = row_start_q;
        stride_d      = stride_q;
        row_words_d   = row_words_q;
        row_num_d     = row_num_q;
        row_idx_d     = row_idx_q;
        req_cnt_d     = req_cnt_q;
        wr_addr_d     = wr_addr_q;
        wr_num_d      = wr_num_q;
        cmd_done_d    = 1'b0;
        cmd_err_d     = 1'b0;
        next_row_addr = row_start_q + stride_q;
`ifdef IDMA_WR_CMD_4K_SPLIT_EN
        words_left_d    = words_left_q;
        words_after     = words_left_q - ROW_CNT_WID'(wr_num_q);
        next_piece_addr = wr_addr_q + (AXI_ADDR_WID'(wr_num_q) << 5);
`endif

        if (cmd_abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        row_start_d = base_aligned;
                        stride_d    = cmd_row_stride & ~WORD_MASK;
                        row_words_d = cmd_row_words;
                        row_num_d   = cmd_row_num;
                        row_idx_d   = '0;
                        req_cnt_d   = '0;
                        if ((cmd_row_words != '0) && (cmd_row_num != '0)) begin
                            state_d   = ISSUE;
                            wr_addr_d = base_aligned;
`ifdef IDMA_WR_CMD_4K_SPLIT_EN
                            wr_num_d     = piece_len(base_aligned[11:0], cmd_row_words);
                            words_left_d = cmd_row_words;
`else
                            wr_num_d  = 32'(cmd_row_words);
`endif
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (push) begin
                        req_cnt_d = req_cnt_q + ROW_CNT_WID'(1);
`ifdef IDMA_WR_CMD_4K_SPLIT_EN
                        if (words_after != '0) begin
                            // Row continues at the 4 KB boundary just reached.
                            wr_addr_d    = next_piece_addr;
                            words_left_d = words_after;
                            wr_num_d     = piece_len(next_piece_addr[11:0], words_after);
                        end else
`endif
                        if (last_row) begin
                            state_d = WAIT_DONE;
                        end else begin
                            row_idx_d   = row_idx_q + ROW_CNT_WID'(1);
                            row_start_d = next_row_addr;
                            wr_addr_d   = next_row_addr;
`ifdef IDMA_WR_CMD_4K_SPLIT_EN
                            words_left_d = row_words_q;
                            wr_num_d     = piece_len(next_row_addr[11:0], row_words_q);
`endif
                        end
                    end
                end

                WAIT_DONE: begin
                    if (wr_if.write_all_done) begin
                        state_d    = IDLE;
                        cmd_done_d = 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_start_q <= '0;
            stride_q    <= '0;
            row_words_q <= '0;
            row_num_q   <= '0;
            row_idx_q   <= '0;
            req_cnt_q   <= '0;
            wr_addr_q   <= '0;
            wr_num_q    <= '0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_start_q <= row_start_d;
            stride_q    <= stride_d;
            row_words_q <= row_words_d;
            row_num_q   <= row_num_d;
            row_idx_q   <= row_idx_d;
            req_cnt_q   <= req_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_num_q    <= wr_num_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

`ifdef IDMA_WR_CMD_4K_SPLIT_EN
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) words_left_q <= '0;
        else        words_left_q <= words_left_d;
    end
`endif

    assign cmd_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign cmd_done       = cmd_done_q;
    assign cmd_err        = cmd_err_q;
    assign req_cnt        = req_cnt_q;
    assign wr_if.wr_req   = push;
    assign wr_if.wr_addr  = wr_addr_q;
    assign wr_if.wr_num   = wr_num_q;

endmodule

// File: tb/tb_idma_wr_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_idma_wr_cmd_gen
// Self-checking bench for idma_wr_cmd_gen. A reference model expands each
// descriptor into expected (address, length) requests on a queue; a monitor
// pops and compares on every wr_req. Honours IDMA_WR_CMD_4K_SPLIT_EN.
// -----------------------------------------------------------------------------
module tb_idma_wr_cmd_gen;

    localparam int unsigned AW = 32;
    localparam int unsigned RW = 16;

    logic          cclk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_addr;
    logic [RW-1:0] cmd_row_words;
    logic [RW-1:0] cmd_row_num;
    logic [AW-1:0] cmd_row_stride;
    logic          cmd_abort;
    logic          busy;
    logic          cmd_done;
    logic          cmd_err;
    logic [RW-1:0] req_cnt;

    int checks   = 0;
    int failures = 0;
    int push_cnt = 0;
    int done_cnt = 0;

    logic [63:0] sb_q[$];

    always #5 cclk = ~cclk;

    idma_wr_cmd_gen_if #(.AXI_ADDR_WID(AW)) wr_if ();

    idma_wr_cmd_gen #(
        .AXI_ADDR_WID(AW),
        .ROW_CNT_WID (RW)
    ) u_dut (
        .cclk          (cclk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_addr (cmd_base_addr),
        .cmd_row_words (cmd_row_words),
        .cmd_row_num   (cmd_row_num),
        .cmd_row_stride(cmd_row_stride),
        .cmd_abort     (cmd_abort),
        .wr_if         (wr_if),
        .busy          (busy),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err),
        .req_cnt       (req_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every push must match the head of the scoreboard.
    always @(negedge cclk) begin : monitor
        logic [63:0] e;
        if (rst_n === 1'b1 && wr_if.wr_req === 1'b1) begin
            push_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_wr_req", 64'(wr_if.wr_req), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("wr_addr", 64'(wr_if.wr_addr), 64'(e[63:32]));
                check_eq("wr_num",  64'(wr_if.wr_num),  64'(e[31:0]));
            end
        end
        if (cmd_done === 1'b1) done_cnt++;
    end

    // Reference model; only the first 'limit' requests are queued.
    task automatic model(input logic [31:0] base, input int words, input int rows,
                         input logic [31:0] stride, input int limit, output int n);
        logic [31:0] start;
        logic [31:0] str;
        logic [31:0] a;
        int left, room, take;
        n     = 0;
        start = base & ~32'h1f;
        str   = stride & ~32'h1f;
        if (words == 0 || rows == 0) return;
        for (int r = 0; r < rows; r++) begin
`ifdef IDMA_WR_CMD_4K_SPLIT_EN
            a    = start;
            left = words;
            while (left > 0) begin
                room = (4096 - int'(a[11:0])) / 32;
                take = (left < room) ? left : room;
                if (n < limit) sb_q.push_back({a, 32'(take)});
                n++;
                a    = a + 32'(take * 32);
                left = left - take;
            end
`else
            a = start;
            if (n < limit) sb_q.push_back({a, 32'(words)});
            n++;
`endif
            start = start + str;
        end
    endtask

    // All driving tasks start and end just after a rising edge.
    task automatic send(input logic [31:0] base, input int words, input int rows,
                        input logic [31:0] stride);
        cmd_base_addr  = base;
        cmd_row_words  = RW'(words);
        cmd_row_num    = RW'(rows);
        cmd_row_stride = stride;
        cmd_valid      = 1'b1;
        @(posedge cclk); #1;
        cmd_valid      = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (sb_q.size() != 0 && k < 500) begin
            @(posedge cclk);
            k++;
        end
        #1;
        check_eq({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic finish_desc(input string tag, input int exp_cnt);
        repeat (2) @(posedge cclk);
        #1;
        check_eq({tag, "_busy_wait"}, 64'(busy), 64'd1);
        check_eq({tag, "_req_cnt"},   64'(req_cnt), 64'(RW'(exp_cnt)));
        wr_if.write_all_done = 1'b1;
        @(posedge cclk); #1;
        wr_if.write_all_done = 1'b0;
        @(negedge cclk);
        check_eq({tag, "_cmd_done"},  64'(cmd_done), 64'd1);
        check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(negedge cclk);
        check_eq({tag, "_done_pulse"}, 64'(cmd_done), 64'd0);
        @(posedge cclk); #1;
    endtask

    task automatic run_full(input string tag, input logic [31:0] base, input int words,
                            input int rows, input logic [31:0] stride);
        int n;
        wr_if.wr_addr_ready = 1'b1;
        model(base, words, rows, stride, 1 << 30, n);
        send(base, words, rows, stride);
        wait_drain(tag);
        finish_desc(tag, n);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n, p0, d0;
        logic [0:5] pat;
        rst_n                = 1'b0;
        cmd_valid            = 1'b0;
        cmd_abort            = 1'b0;
        cmd_base_addr        = '0;
        cmd_row_words        = '0;
        cmd_row_num          = '0;
        cmd_row_stride       = '0;
        wr_if.wr_addr_ready  = 1'b0;
        wr_if.write_all_done = 1'b0;

        // Reset state
        repeat (2) @(negedge cclk);
        check_eq("rst_wr_req",   64'(wr_if.wr_req),  64'd0);
        check_eq("rst_wr_addr",  64'(wr_if.wr_addr), 64'd0);
        check_eq("rst_wr_num",   64'(wr_if.wr_num),  64'd0);
        check_eq("rst_cmd_done", 64'(cmd_done), 64'd0);
        check_eq("rst_cmd_err",  64'(cmd_err),  64'd0);
        check_eq("rst_busy",     64'(busy),     64'd0);
        check_eq("rst_req_cnt",  64'(req_cnt),  64'd0);
        @(posedge cclk); #1;
        rst_n = 1'b1;
        @(negedge cclk);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge cclk); #1;

        // Basic 3-row descriptor
        p0 = push_cnt;
        run_full("basic", 32'h1000_0000, 4, 3, 32'h200);
        check_eq("basic_pushes", 64'(push_cnt - p0), 64'd3);

        // Back-pressure 1,0,0,1,0,1; write_all_done during ISSUE is ignored
        pat = 6'b100101;
        p0  = push_cnt;
        d0  = done_cnt;
        wr_if.wr_addr_ready = 1'b0;
        model(32'h1000_0000, 4, 3, 32'h200, 1 << 30, n);
        send(32'h1000_0000, 4, 3, 32'h200);
        for (int i = 0; i < 6; i++) begin
            wr_if.wr_addr_ready  = pat[i];
            wr_if.write_all_done = (i == 1);
            @(posedge cclk); #1;
        end
        wr_if.write_all_done = 1'b0;
        wr_if.wr_addr_ready  = 1'b1;
        wait_drain("stall");
        check_eq("stall_pushes",    64'(push_cnt - p0), 64'd3);
        check_eq("stall_no_done",   64'(done_cnt - d0), 64'd0);
        finish_desc("stall", n);

        // Zero-sized descriptors
        for (int v = 0; v < 2; v++) begin
            p0 = push_cnt;
            d0 = done_cnt;
            if (v == 0) send(32'h2000, 0, 5, 32'h100);
            else        send(32'h2000, 4, 0, 32'h100);
            @(negedge cclk);
            check_eq("err_pulse",     64'(cmd_err),   64'd1);
            check_eq("err_cmd_ready", 64'(cmd_ready), 64'd1);
            check_eq("err_busy",      64'(busy),      64'd0);
            @(negedge cclk);
            check_eq("err_pulse_end", 64'(cmd_err),   64'd0);
            repeat (3) @(posedge cclk);
            #1;
            check_eq("err_no_push", 64'(push_cnt - p0), 64'd0);
            check_eq("err_no_done", 64'(done_cnt - d0), 64'd0);
        end

        // 4 KB boundary crossing
        run_full("split", 32'h0000_0F80, 8, 1, 32'h0);

        // Abort after the second push
        p0 = push_cnt;
        d0 = done_cnt;
        wr_if.wr_addr_ready = 1'b0;
        model(32'h0000_2000, 2, 4, 32'h100, 2, n);
        send(32'h0000_2000, 2, 4, 32'h100);
        wr_if.wr_addr_ready = 1'b1;
        repeat (2) begin @(posedge cclk); #1; end
        wr_if.wr_addr_ready = 1'b0;
        cmd_abort = 1'b1;
        @(posedge cclk); #1;
        cmd_abort = 1'b0;
        @(negedge cclk);
        check_eq("abort_busy",      64'(busy),      64'd0);
        check_eq("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge cclk); #1;
        wr_if.wr_addr_ready  = 1'b1;
        wr_if.write_all_done = 1'b1;
        @(posedge cclk); #1;
        wr_if.write_all_done = 1'b0;
        repeat (5) begin @(posedge cclk); #1; end
        check_eq("abort_pushes",  64'(push_cnt - p0), 64'd2);
        check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("abort_sb",      64'(sb_q.size()),   64'd0);
        run_full("after_abort", 32'h1000_0000, 4, 3, 32'h200);

        // Reset after the first push
        p0 = push_cnt;
        d0 = done_cnt;
        wr_if.wr_addr_ready = 1'b0;
        model(32'h0000_3000, 2, 4, 32'h100, 1, n);
        send(32'h0000_3000, 2, 4, 32'h100);
        wr_if.wr_addr_ready = 1'b1;
        @(posedge cclk); #1;
        rst_n = 1'b0;
        @(negedge cclk);
        check_eq("mrst_wr_req",  64'(wr_if.wr_req), 64'd0);
        check_eq("mrst_busy",    64'(busy),         64'd0);
        check_eq("mrst_req_cnt", 64'(req_cnt),      64'd0);
        check_eq("mrst_wr_addr", 64'(wr_if.wr_addr), 64'd0);
        @(posedge cclk); #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge cclk); #1; end
        check_eq("mrst_pushes",  64'(push_cnt - p0), 64'd1);
        check_eq("mrst_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("mrst_busy_after", 64'(busy),       64'd0);
        run_full("after_rst", 32'h1000_0000, 4, 3, 32'h200);

        // Address wrap at the top of the address space
        run_full("wrap", 32'hFFFF_FF00, 4, 2, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idma_wr_cmd_gen.md
IDMA_WR_CMD_GEN -- requirements
Module: idma_wr_cmd_gen

Interface
REQ-001 Parameter: AXI_ADDR_WID, default 32, byte-address width of wr_addr/cmd_base_addr/cmd_row_stride.
REQ-002 Parameter: ROW_CNT_WID, default 16, width of cmd_row_words, cmd_row_num, row index and req_cnt.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to that clock.
REQ-004 Ports (name  direction  width  meaning):
- cclk  in  1  core clock.
- rst_n  in  1  async active-low reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accept; high only in IDLE.
- cmd_base_addr  in  AXI_ADDR_WID  first-row byte address.
- cmd_row_words  in  ROW_CNT_WID  256-bit words per row.
- cmd_row_num  in  ROW_CNT_WID  number of rows.
- cmd_row_stride  in  AXI_ADDR_WID  byte distance between row starts.
- cmd_abort  in  1  synchronous abort pulse.
- wr_req  out  1  address-FIFO push.
- wr_addr  out  AXI_ADDR_WID  request byte address.
- wr_num  out  32  request length in words.
- wr_addr_ready  in  1  address FIFO not full.
- write_all_done  in  1  completion pulse from write channel.
- busy  out  1  state != IDLE.
- cmd_done  out  1  one-cycle descriptor-complete pulse.
- cmd_err  out  1  one-cycle illegal-descriptor pulse.
- req_cnt  out  ROW_CNT_WID  requests pushed for the current descriptor (debug).

Function
REQ-005 FSM states IDLE, ISSUE, WAIT_DONE; IDLE->ISSUE on cmd_valid&cmd_ready with cmd_row_words!=0 and cmd_row_num!=0.
REQ-006 Accept with cmd_row_words==0 or cmd_row_num==0: cmd_err=1 the next cycle, stay IDLE, no wr_req, no cmd_done.
REQ-007 On accept, latch all cmd_* fields, force address bits [4:0] of base and stride to zero, clear req_cnt and row index.
REQ-008 wr_req = (state==ISSUE) & wr_addr_ready, combinational; wr_addr/wr_num are registered and stable while in ISSUE without a push.
REQ-009 Each cycle with wr_req=1 SHALL push exactly one request; req_cnt increments by 1 (wraps at 2^ROW_CNT_WID).
REQ-010 After the last request of a row, next row address = row start + stride, modulo 2^AXI_ADDR_WID.
REQ-011 After the last request of the last row, ISSUE->WAIT_DONE on the same edge; wr_req is 0 in WAIT_DONE.
REQ-012 WAIT_DONE->IDLE on write_all_done=1; cmd_done=1 for exactly the following cycle, coincident with cmd_ready=1.
REQ-013 write_all_done in IDLE or ISSUE SHALL be ignored (no state, counter or output effect).
REQ-014 cmd_abort=1 in any state: next state IDLE, no cmd_done, pending requests discarded; abort has priority over push, accept and write_all_done in the same cycle.
REQ-015 wr_addr_ready low for any number of cycles SHALL stall ISSUE with no loss or duplication of requests.

Reset
REQ-016 While rst_n=0: state IDLE, wr_req=0, wr_addr=0, wr_num=0, cmd_done=0, cmd_err=0, busy=0, req_cnt=0, all latched fields 0; cmd_ready=1 on reset release.
REQ-017 Reset asserted mid-descriptor SHALL abandon it with no further wr_req after release.

Configuration
REQ-018 Macro IDMA_WR_CMD_4K_SPLIT_EN defined: each row SHALL be split at every 4 KB boundary; wr_num = min(words remaining in row, (4096 - addr[11:0])/32), next piece starts at the boundary.
REQ-019 Macro undefined: exactly one request per row, wr_addr = row start, wr_num = cmd_row_words zero-extended; no split logic synthesized.

Verification
REQ-020 base=0x1000_0000, words=4, rows=3, stride=0x200, ready=1 -> 3 consecutive wr_req: (0x1000_0000,4),(0x1000_0200,4),(0x1000_0400,4); then write_all_done -> cmd_done 1 cycle later, req_cnt=3.
REQ-021 Same descriptor, wr_addr_ready toggling 1,0,0,1,0,1 -> exactly 3 pushes, same address/num sequence, no duplicates.
REQ-022 words=0, rows=5 -> cmd_err pulse next cycle, no wr_req, cmd_ready stays 1.
REQ-023 With IDMA_WR_CMD_4K_SPLIT_EN: base=0x0000_0F80, words=8, rows=1 -> (0x0000_0F80,4),(0x0000_1000,4); without it -> single (0x0000_0F80,8).
REQ-024 rows=4, cmd_abort after 2nd push, and separately rst_n=0 after 1st push -> no further wr_req, no cmd_done, busy=0, next descriptor accepted normally.
REQ-025 base=0xFFFF_FF00, stride=0x100, rows=2 -> second wr_addr=0x0000_0000 (wrap).
